// File: rtl/mips_defs.sv
// Shared definitions for the MIPS core: next-PC select codes and reset constants.
// The decoder drives npc_op with these same codes.
package mips_defs;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_BR   = 2'b01,
        NPC_JIMM = 2'b10,
        NPC_JREG = 2'b11
    } npc_op_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Branch and jump targets are formed from the instruction currently in D.
module npc_calc
    import mips_defs::*;
(
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [15:0] d_imm16,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs_val,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] br_target;

    assign seq_pc    = f_pc + 32'd4;
    assign br_target = d_pc + 32'd4 + (sign_ext16(d_imm16) << 2);

    always_comb begin
        // NOTE: default assigned first so every path drives npc and no latch is inferred.
        npc = seq_pc;
        case (npc_op_e'(npc_op))
            NPC_SEQ:  npc = seq_pc;
            NPC_BR:   npc = br_taken ? br_target : seq_pc;
            NPC_JIMM: npc = {d_pc[31:28], d_imm26, 2'b00};
            NPC_JREG: npc = d_rs_val;
            default:  npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the F/D pipeline register.
// One branch delay slot, so redirects never squash the word already fetched.
module fetch_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC,
    parameter logic [31:0] NOP_WORD_P = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    input  logic        stall,
    input  logic        fd_clr,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] D_Imm16,
    input  logic [25:0] D_Imm26,
    input  logic [31:0] D_rs_val,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic        D_valid
);

    logic [31:0] npc;

    npc_calc u_npc_calc (
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .f_pc     (F_PC),
        .d_pc     (D_PC),
        .d_imm16  (D_Imm16),
        .d_imm26  (D_Imm26),
        .d_rs_val (D_rs_val),
        .npc      (npc)
    );

    // A stall freezes everything, including a pending redirect whose operands may be stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            F_PC    <= RESET_PC_P;
            D_Instr <= NOP_WORD_P;
            D_PC    <= RESET_PC_P;
            D_valid <= 1'b0;
        end else if (!stall) begin
            // NOTE: non-blocking so D_PC captures the pre-edge F_PC while F_PC advances.
            F_PC    <= npc;
            D_PC    <= F_PC;
            D_Instr <= fd_clr ? NOP_WORD_P : F_Instr;
            D_valid <= !fd_clr;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and F/D pipeline register of the five-stage MIPS core. It holds the PC, drives the instruction-memory address and latches the fetched word plus its PC into the D stage. The D-stage decoder consumes `D_Instr`. The block computes next-PC from D-stage redirect requests: branch, j/jal, jr/jalr. The architecture uses one branch delay slot, so a redirect never squashes the instruction already fetched.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; first fetch address.
- NOP_WORD, 32'h0000_0000, word loaded into `D_Instr` on reset or clear (sll $0,$0,0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- F_PC  out  32  current fetch PC; drives instruction-memory address.
- F_Instr  in  32  instruction word from instruction memory (combinational read of `F_PC`).
- stall  in  1  from hazard unit; freezes PC and F/D register.
- fd_clr  in  1  nullify: load NOP into F/D instead of `F_Instr` (delay-slot annul).
- npc_op  in  2  D-stage redirect kind: 00 seq, 01 branch, 10 jump-imm, 11 jump-reg.
- br_taken  in  1  D-stage branch comparison result; meaningful only when npc_op=01.
- D_Imm16  in  16  offset field of the instruction in D.
- D_Imm26  in  26  index field of the instruction in D.
- D_rs_val  in  32  forwarded GPR[rs] value in D, for jr/jalr.
- D_Instr  out  32  F/D register: instruction.
- D_PC  out  32  F/D register: PC of `D_Instr`.
- D_valid  out  1  1 when `D_Instr` is a real fetched instruction; 0 for a reset or clear bubble.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - F_PC=RESET_PC.
  - D_Instr=NOP_WORD, D_PC=RESET_PC, D_valid=0.
  - Deassertion takes effect at the next rising edge; the first fetch is RESET_PC.
- Next-PC, combinational:
  - seq: F_PC+4.
  - branch: D_PC+4+(sign_ext(D_Imm16)<<2) if br_taken, else F_PC+4.
  - jump-imm: {D_PC[31:28], D_Imm26, 2'b00}.
  - jump-reg: D_rs_val, used unmodified with no alignment fix-up.
  - All adds are 32-bit modulo 2^32; wrap-around is silent.
- Each rising edge, stall=1:
  - F_PC, D_Instr, D_PC and D_valid all hold.
  - npc_op and fd_clr are ignored, because the redirecting instruction is itself stalled in D and its operands may be stale.
- Each rising edge, stall=0, fd_clr=0:
  - F_PC<=next-PC.
  - D_Instr<=F_Instr, D_PC<=F_PC, D_valid<=1.
- Each rising edge, stall=0, fd_clr=1:
  - F_PC<=next-PC, so the redirect still applies.
  - D_Instr<=NOP_WORD, D_PC<=F_PC, D_valid<=0.
- Priority: reset > stall > fd_clr > normal.
- Delay slot: when a branch or jump sits in D, the word at its PC+4 is in F. That word enters D on the next unstalled edge unless fd_clr=1.
- Latency: redirect target is fetched one cycle after the redirecting instruction's first unstalled D cycle.
- Back-to-back redirects (jump in a delay slot) are taken in order, one per unstalled edge. There is no special handling.
- Reset asserted mid-stall or mid-redirect discards all state. No pending redirect survives reset.
- No outputs are driven X at any time after the first reset.

Decomposition:
- Shared package `mips_defs`:
  - NPC_SEQ/NPC_BR/NPC_JIMM/NPC_JREG 2-bit codes.
  - RESET_PC constant.
  - NOP_WORD constant.
  - Decoder emits the same npc_op codes from this package.
- One sub-module `npc_calc` (purely combinational next-PC mux and adders). The PC register and F/D register stay in `fetch_stage`.

Test Plan:
- Reset then 3 free-running cycles, npc_op=00:
  - F_PC = 3000, 3004, 3008, 300C.
  - D_PC lags one cycle.
  - D_valid rises at the first edge after release.
- Branch at D_PC=3008, D_Imm16=16'hFFFE, br_taken=1:
  - Next F_PC=3004 (3008+4-8).
  - D receives delay-slot word from 300C.
- Same branch with br_taken=0:
  - F_PC=3010 (sequential).
  - npc_op=01 alone never redirects.
- jal, D_PC=0000_3010, D_Imm26=26'h0000C40:
  - F_PC=0000_3100.
- jr with D_rs_val=0000_3020 and stall=1 for 2 cycles, then 0:
  - F_PC, D_Instr and D_PC are frozen during the stall.
  - F_PC=3020 after the release edge.
- fd_clr=1 with a taken branch:
  - D_Instr=0, D_valid=0.
  - F_PC = branch target.
  - Reset asserted asynchronously mid-cycle returns F_PC to 3000 immediately, with no clock edge.
